// File: rtl/lbp_engine.sv
// Local-binary-pattern engine: streams a grayscale frame from a synchronous memory,
// slides a 3x3 window along each row and writes one 8-bit code per interior pixel.
module lbp_engine #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int DW    = 8,
  parameter int AW    = 14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          gray_ready,
  input  logic [DW-1:0] gray_data,
  input  logic          border_zero,
  output logic [AW-1:0] gray_addr,
  output logic          gray_req,
  output logic [AW-1:0] lbp_addr,
  output logic          lbp_valid,
  output logic [7:0]    lbp_data,
  output logic          finish
);

  typedef enum logic [2:0] {IDLE, FILL, SHIFT, CALC, BORDER, DONE} state_t;

  localparam logic [AW-1:0] W_A       = AW'(IMG_W);
  localparam logic [AW-1:0] STEP_BACK = AW'(2*IMG_W-1);
  localparam logic [AW-1:0] EDGE_STEP = AW'(IMG_W-1);
  localparam logic [AW-1:0] LAST_COL  = AW'(IMG_W-2);
  localparam logic [AW-1:0] LAST_ROW  = AW'(IMG_H-2);
  localparam logic [AW-1:0] FIRST_OUT = AW'(IMG_W+1);
  localparam logic [AW-1:0] TOP_END   = AW'(IMG_W-1);
  localparam logic [AW-1:0] BOT_START = AW'((IMG_H-1)*IMG_W);
  localparam logic [AW-1:0] BOT_END   = AW'(IMG_H*IMG_W-1);
  localparam logic [AW-1:0] SIDE_END  = AW'((IMG_H-1)*IMG_W-1);

  state_t          state;
  // Window kept column-major (index = col*3 + row) so that every capture is a
  // plain shift: 9 captures load a full window, 3 captures slide it one column.
  logic [DW-1:0]   win  [9];
  logic [DW-1:0]   nwin [9];
  logic [3:0]      iss, got, need;
  logic [1:0]      vrow;
  logic            pend, bz, bside;
  logic [1:0]      bphase;
  logic [AW-1:0]   row, col, oaddr;
  logic [7:0]      code;

  always_comb begin
    for (int i = 0; i < 8; i++) nwin[i] = win[i+1];
    nwin[8] = gray_data;
    need = (state == FILL) ? 4'd9 : 4'd3;
  end

  // Code is formed from the window as it will stand after the final capture.
  always_comb begin
    code[0] = nwin[0] >= nwin[4];
    code[1] = nwin[3] >= nwin[4];
    code[2] = nwin[6] >= nwin[4];
    code[3] = nwin[1] >= nwin[4];
    code[4] = nwin[7] >= nwin[4];
    code[5] = nwin[2] >= nwin[4];
    code[6] = nwin[5] >= nwin[4];
    code[7] = nwin[8] >= nwin[4];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      gray_addr <= '0;
      gray_req  <= 1'b0;
      lbp_addr  <= '0;
      lbp_valid <= 1'b0;
      lbp_data  <= '0;
      finish    <= 1'b0;
      for (int i = 0; i < 9; i++) win[i] <= '0;
      iss       <= '0;
      got       <= '0;
      vrow      <= '0;
      pend      <= 1'b0;
      bz        <= 1'b0;
      bside     <= 1'b0;
      bphase    <= '0;
      row       <= AW'(1);
      col       <= AW'(1);
      oaddr     <= FIRST_OUT;
    end else begin
      pend <= gray_req && gray_ready;
      // Reads walk each column top to bottom; stepping back 2W-1 from a column's
      // bottom always lands on the next window's first read, even across rows.
      if (gray_req && gray_ready) begin
        if (vrow == 2'd2) begin
          gray_addr <= gray_addr - STEP_BACK;
          vrow      <= '0;
        end else begin
          gray_addr <= gray_addr + W_A;
          vrow      <= vrow + 2'd1;
        end
        iss <= iss + 4'd1;
        if (iss + 4'd1 == need) gray_req <= 1'b0;
      end
      if (pend) begin
        for (int i = 0; i < 9; i++) win[i] <= nwin[i];
        got <= got + 4'd1;
      end

      case (state)
        IDLE: if (gray_ready) begin
          state    <= FILL;
          gray_req <= 1'b1;
          bz       <= border_zero;
          iss      <= '0;
          got      <= '0;
        end
        FILL, SHIFT: if (pend && got == need - 4'd1) begin
          state     <= CALC;
          lbp_valid <= 1'b1;
          lbp_data  <= code;
          lbp_addr  <= oaddr;
        end
        CALC: begin
          lbp_valid <= 1'b0;
          iss       <= '0;
          got       <= '0;
          if (col < LAST_COL) begin
            col      <= col + AW'(1);
            oaddr    <= oaddr + AW'(1);
            state    <= SHIFT;
            gray_req <= 1'b1;
          end else if (row < LAST_ROW) begin
            row      <= row + AW'(1);
            col      <= AW'(1);
            oaddr    <= oaddr + AW'(3);
            state    <= FILL;
            gray_req <= 1'b1;
          end else if (bz) begin
            state     <= BORDER;
            lbp_valid <= 1'b1;
            lbp_data  <= '0;
            lbp_addr  <= '0;
            bphase    <= '0;
            bside     <= 1'b0;
          end else begin
            state  <= DONE;
            finish <= 1'b1;
          end
        end
        // Border order: top row, bottom row, then left/right pairs of middle rows.
        BORDER: case (bphase)
          2'd0: if (lbp_addr == TOP_END) begin
            lbp_addr <= BOT_START;
            bphase   <= 2'd1;
          end else lbp_addr <= lbp_addr + AW'(1);
          2'd1: if (lbp_addr == BOT_END) begin
            lbp_addr <= W_A;
            bphase   <= 2'd2;
            bside    <= 1'b0;
          end else lbp_addr <= lbp_addr + AW'(1);
          default: if (!bside) begin
            lbp_addr <= lbp_addr + EDGE_STEP;
            bside    <= 1'b1;
          end else if (lbp_addr == SIDE_END) begin
            lbp_valid <= 1'b0;
            finish    <= 1'b1;
            state     <= DONE;
          end else begin
            lbp_addr <= lbp_addr + AW'(1);
            bside    <= 1'b0;
          end
        endcase
        DONE:    finish <= 1'b1;
        default: state  <= IDLE;
      endcase
    end
  end

endmodule
